// File: rtl/dmem_bus_responder.sv
// rtl/dmem_bus_responder.sv - word RAM responder for a req/gnt/rvalid data bus
// Grants after a configurable delay, executes reads/writes at the handshake
// edge and returns in-order responses a fixed number of cycles later.
module dmem_bus_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH_WORDS     = 256,
    parameter int GNT_DELAY       = 0,
    parameter int RVALID_DELAY    = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       data_req_i,
    output logic                                       data_gnt_o,
    input  logic [31:0]                                data_addr_i,
    input  logic                                       data_we_i,
    input  logic [3:0]                                 data_be_i,
    input  logic [DATA_WIDTH-1:0]                      data_wdata_i,
    output logic                                       data_rvalid_o,
    output logic [DATA_WIDTH-1:0]                      data_rdata_o,
    output logic                                       data_err_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_o
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(GNT_DELAY);
    // First WAIT cycle already counts as one cycle of delay; with no delay
    // the counter simply stays at its saturation value of zero.
    localparam logic [CW-1:0] CNT_FIRST = (GNT_DELAY > 0) ? CW'(1) : CW'(0);
    localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUTSTANDING);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_next;
    logic                   gnt;
    logic                   hs;
    logic                   retire;
    logic                   room;
    logic                   addr_err;
    logic [IW-1:0]          word_idx;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic [DATA_WIDTH-1:0]  d_in;
    logic [OW-1:0]          outstanding;

    logic [DATA_WIDTH-1:0]  mem [DEPTH_WORDS];

    logic [RVALID_DELAY-1:0] pv;
    logic [RVALID_DELAY-1:0] pe;
    logic [DATA_WIDTH-1:0]   pd [RVALID_DELAY];

    // A retiring response frees its slot in the same cycle, so a full
    // responder can still grant while rvalid is high.
    assign retire   = pv[RVALID_DELAY-1];
    assign room     = (outstanding != OUT_MAX) || retire;
    assign hs       = data_req_i && gnt;
    assign addr_err = (data_addr_i[1:0] != 2'b00) || (data_addr_i[31:IW+2] != '0);
    assign word_idx = data_addr_i[IW+1:2];
    assign rd_word  = mem[word_idx];
    assign d_in     = (hs && !data_we_i && !addr_err) ? rd_word : '0;

    // Grant FSM state and delay counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Grant FSM next state: every request pays the full delay again
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (data_req_i && !gnt) begin
                    state_next = S_WAIT;
                    cnt_next   = CNT_FIRST;
                end else begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            end
            S_WAIT: begin
                if (!data_req_i || gnt) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Grant FSM output: combinational grant once delay and credit allow
    always_comb begin
        gnt = 1'b0;
        if (!rst && data_req_i && room) begin
            case (state)
                S_IDLE:  gnt = (GNT_DELAY == 0);
                S_WAIT:  gnt = (cnt == CNT_MAX);
                default: gnt = 1'b0;
            endcase
        end
    end

    assign data_gnt_o = gnt;

    // RAM write at the handshake edge; contents survive reset
    always_ff @(posedge clk) begin
        if (hs && data_we_i && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline: read data is captured here so later writes cannot alter it
    always_ff @(posedge clk) begin
        if (rst) begin
            pv <= '0;
            pe <= '0;
            for (int i = 0; i < RVALID_DELAY; i++) begin
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= hs;
            pe[0] <= hs && addr_err;
            pd[0] <= d_in;
            for (int i = 1; i < RVALID_DELAY; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    // In-flight counter: handshake adds one, rvalid retires one
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (hs && !retire) begin
            outstanding <= outstanding + OW'(1);
        end else if (!hs && retire) begin
            outstanding <= outstanding - OW'(1);
        end
    end

    assign data_rvalid_o = pv[RVALID_DELAY-1];
    assign data_err_o    = pe[RVALID_DELAY-1];
    assign data_rdata_o  = pd[RVALID_DELAY-1];
    assign outstanding_o = outstanding;

endmodule

// File: tb/tb_dmem_bus_responder.sv
// tb/tb_dmem_bus_responder.sv - scoreboard bench for dmem_bus_responder
module tb_dmem_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [3:0]  errs;
    logic [31:0] addr  [4];
    logic [31:0] wdata [4];
    logic [31:0] rdata [4];
    logic [3:0]  be    [4];
    logic [1:0]  outst [4];

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    bit phase2 = 1'b0;

    typedef struct {
        int          id;
        logic        err;
        logic [31:0] rd;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;

    // Instance configs: 0 = (gnt 0, rv 1, max 2), 1 = (3, 2, 2), 2 = (0, 3, 1), 3 = (0, 3, 2)
    function automatic int rd_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : 3;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int GDG = (g == 1) ? 3 : 0;
        localparam int RDG = (g == 0) ? 1 : (g == 1) ? 2 : 3;
        localparam int MOG = (g == 2) ? 1 : 2;
        localparam int OWG = $clog2(MOG + 1);
        logic [OWG-1:0] o_loc;
        dmem_bus_responder #(
            .DATA_WIDTH(32), .DEPTH_WORDS(256), .GNT_DELAY(GDG),
            .RVALID_DELAY(RDG), .MAX_OUTSTANDING(MOG)
        ) u_dut (
            .clk(clk), .rst(rst),
            .data_req_i(req[g]), .data_gnt_o(gnt[g]),
            .data_addr_i(addr[g]), .data_we_i(we[g]),
            .data_be_i(be[g]), .data_wdata_i(wdata[g]),
            .data_rvalid_o(rvalid[g]), .data_rdata_o(rdata[g]),
            .data_err_o(errs[g]), .outstanding_o(o_loc)
        );
        assign outst[g] = 2'(o_loc);
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: pop and compare every response the DUTs present
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e_mon = exp_q.pop_front();
            check("rvalid_missing", 32'(rvalid[e_mon.id]), 32'd1);
        end
        for (int g = 0; g < 4; g++) begin
            if (rvalid[g]) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_unexpected", 32'(rvalid[g]), 32'd0);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("resp_id", g, e_mon.id);
                    check("rvalid_cycle", cyc, e_mon.due);
                    check("resp_err", 32'(errs[g]), 32'(e_mon.err));
                    check("resp_rdata", rdata[g], e_mon.rd);
                end
            end
        end
        if (phase2) begin
            check("outstanding_max", 32'(outst[2] > 2'd1), 32'd0);
        end
    end

    // One bus transaction: hold req until granted, then queue the expected response
    task automatic txn(input int g, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic ee, input logic [31:0] erd,
                       input int ewait);
        int   waits = 0;
        bit   got   = 1'b0;
        exp_t e;
        req[g] = 1'b1; we[g] = w; addr[g] = a; be[g] = b; wdata[g] = d;
        while (!got && waits <= 20) begin
            @(negedge clk);
            if (gnt[g]) begin
                got   = 1'b1;
                e.id  = g;
                e.err = ee;
                e.rd  = erd;
                e.due = cyc + rd_of(g);
                exp_q.push_back(e);
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        check("gnt_wait", waits, ewait);
        req[g] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req = '0;
        we  = '0;
        for (int g = 0; g < 4; g++) begin
            addr[g] = '0; wdata[g] = '0; be[g] = '0;
        end
        idle(3);
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            check("reset_gnt", 32'(gnt[g]), 32'd0);
            check("reset_rvalid", 32'(rvalid[g]), 32'd0);
            check("reset_rdata", rdata[g], 32'd0);
            check("reset_err", 32'(errs[g]), 32'd0);
            check("reset_outstanding", 32'(outst[g]), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // Instance 0: immediate grant, one-cycle response, back-to-back traffic
        txn(0, 1, 32'h10,  4'hF, 32'hDEADBEEF, 0, 32'h0,        0);
        txn(0, 0, 32'h10,  4'hF, 32'h0,        0, 32'hDEADBEEF, 0);
        txn(0, 1, 32'h10,  4'hF, 32'h11223344, 0, 32'h0,        0);
        txn(0, 1, 32'h10,  4'h5, 32'hAABBCCDD, 0, 32'h0,        0);
        txn(0, 0, 32'h10,  4'hF, 32'h0,        0, 32'h11BB33DD, 0);
        txn(0, 0, 32'h400, 4'hF, 32'h0,        1, 32'h0,        0);
        txn(0, 1, 32'h13,  4'hF, 32'h0,        1, 32'h0,        0);
        txn(0, 0, 32'h10,  4'hF, 32'h0,        0, 32'h11BB33DD, 0);
        txn(0, 1, 32'h3FC, 4'hF, 32'h0F0F1234, 0, 32'h0,        0);
        txn(0, 0, 32'h3FC, 4'hF, 32'h0,        0, 32'h0F0F1234, 0);
        txn(0, 0, 32'h3FE, 4'hF, 32'h0,        1, 32'h0,        0);
        txn(0, 1, 32'h24,  4'hF, 32'h01020304, 0, 32'h0,        0);
        txn(0, 1, 32'h24,  4'h0, 32'hFFFFFFFF, 0, 32'h0,        0);
        txn(0, 0, 32'h24,  4'hF, 32'h0,        0, 32'h01020304, 0);
        txn(0, 1, 32'h20,  4'hF, 32'h5,        0, 32'h0,        0);
        txn(0, 0, 32'h20,  4'hF, 32'h0,        0, 32'h5,        0);
        idle(4);

        // Instance 1: three-cycle grant delay, two-cycle response, dropped request
        txn(1, 1, 32'h8, 4'hF, 32'h12345678, 0, 32'h0,        3);
        txn(1, 0, 32'h8, 4'hF, 32'h0,        0, 32'h12345678, 3);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8; be[1] = 4'hF; wdata[1] = 32'hFFFFFFFF;
        repeat (2) begin
            @(negedge clk);
            check("drop_gnt", 32'(gnt[1]), 32'd0);
            @(posedge clk); #1;
        end
        req[1] = 1'b0;
        idle(1);
        txn(1, 0, 32'h8, 4'hF, 32'h0,        0, 32'h12345678, 3);
        idle(4);

        // Instance 2: single credit, three-cycle response -> one handshake every 3 cycles
        phase2 = 1'b1;
        txn(2, 1, 32'h0, 4'hF, 32'hA5A5A5A5, 0, 32'h0,        0);
        txn(2, 0, 32'h0, 4'hF, 32'h0,        0, 32'hA5A5A5A5, 2);
        txn(2, 0, 32'h0, 4'hF, 32'h0,        0, 32'hA5A5A5A5, 2);
        txn(2, 0, 32'h0, 4'hF, 32'h0,        0, 32'hA5A5A5A5, 2);
        idle(5);
        phase2 = 1'b0;

        // Instance 3: reset with two responses in flight
        txn(3, 1, 32'h40, 4'hF, 32'hCAFEF00D, 0, 32'h0, 0);
        txn(3, 0, 32'h44, 4'hF, 32'h0,        0, 32'h0, 0);
        check("inflight_before_reset", 32'(outst[3]), 32'd2);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(6);
        check("outstanding_after_reset", 32'(outst[3]), 32'd0);
        txn(3, 0, 32'h40, 4'hF, 32'h0, 0, 32'hCAFEF00D, 0);
        idle(8);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
